// File: rtl/demux2_stream.sv
// Purpose : 1-to-2 stream demultiplexer steering each word to output A or B by in_sel, with a small FIFO per output.
// Latency : 1 cycle from an accepted input word to x_valid/x_data; no same-cycle bypass.
// Backpr. : in_ready = not full(FIFO[in_sel]); a stalled output only blocks words that select it.
//
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/in_sel/in_data  - producer side
//           a_valid/a_ready/a_data            - consumer A (in_sel = 0)
//           b_valid/b_ready/b_data            - consumer B (in_sel = 1)
//           a_count/b_count                   - pop counters, only with DEMUX_CNT_EN defined
// Build   : define DEMUX_CNT_EN to add the per-output delivered-word counters (width CNT_W).

// Single-output FIFO used for each demux leg. Occupancy is tracked by
// pointers one bit wider than the index: equal pointers mean EMPTY, equal
// indices with differing wrap bits mean FULL, anything else is PARTIAL.
module demux2_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_full,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_pop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    // Last word handed to the consumer; shown while the FIFO is empty so the
    // data output holds steady instead of exposing a stale storage slot.
    logic [WIDTH-1:0] r_last;

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_push;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_vld    = !w_empty;
    assign o_pop    = o_vld && i_rdy;
    // Upstream already gates with in_ready; guard again so a full FIFO can never be overwritten.
    assign w_push   = i_push && !o_full;
    assign o_dat    = o_vld ? r_mem[w_rd_idx] : r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (o_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[w_rd_idx];
            end
        end
    end

    // Storage needs no reset: it is only observed through o_dat while the
    // pointers say the slot holds a pushed word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= i_push_dat;
        end
    end
endmodule

module demux2_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2     // power of two, at least 2
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] a_count
    , output logic [CNT_W-1:0] b_count
`endif
);
    logic w_a_full;
    logic w_b_full;
    logic w_a_push;
    logic w_b_push;
    logic w_a_pop;
    logic w_b_pop;

    // Readiness depends only on the selected FIFO's fill state, never on the
    // consumers' ready, so there is no combinational path output->input.
    assign in_ready = in_sel ? !w_b_full : !w_a_full;
    assign w_a_push = in_valid && in_ready && !in_sel;
    assign w_b_push = in_valid && in_ready &&  in_sel;

    demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_a_push),
        .i_push_dat (in_data),
        .o_full     (w_a_full),
        .o_vld      (a_valid),
        .i_rdy      (a_ready),
        .o_dat      (a_data),
        .o_pop      (w_a_pop)
    );

    demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_b_push),
        .i_push_dat (in_data),
        .o_full     (w_b_full),
        .o_vld      (b_valid),
        .i_rdy      (b_ready),
        .o_dat      (b_data),
        .o_pop      (w_b_pop)
    );

`ifdef DEMUX_CNT_EN
    // Counts delivered words (pops), wrapping naturally at CNT_W bits.
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_a_pop) begin
                r_a_count <= r_a_count + CNT_W'(1);
            end
            if (w_b_pop) begin
                r_b_count <= r_b_count + CNT_W'(1);
            end
        end
    end

    assign a_count = r_a_count;
    assign b_count = r_b_count;
`else
    // Pop strobes only feed the optional counters.
    logic w_unused_pops;
    assign w_unused_pops = w_a_pop ^ w_b_pop;
`endif
endmodule

// File: tb/tb_demux2_stream.sv
module tb_demux2_stream;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
`ifdef DEMUX_CNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    always #5 clk = ~clk;

    demux2_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_CNT_EN
        , .a_count (a_count)
        , .b_count (b_count)
`endif
    );

    // Reference model: each output is a bounded queue of words; the data
    // output shows the queue head, or the last delivered word when empty.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [31:0] rec_b[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        cnt_a  = '0;
        cnt_b  = '0;
    endtask

    task automatic check_outputs(input string ph);
        logic exp_rdy;
        exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        chk({ph, ".a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
        chk({ph, ".b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
        chk({ph, ".a_data"}, a_data, (qa.size() != 0) ? qa[0] : last_a);
        chk({ph, ".b_data"}, b_data, (qb.size() != 0) ? qb[0] : last_b);
        chk({ph, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
`ifdef DEMUX_CNT_EN
        chk({ph, ".a_count"}, 32'(a_count), 32'(cnt_a));
        chk({ph, ".b_count"}, 32'(b_count), 32'(cnt_b));
`endif
    endtask

    // One clock: check outputs against the model, then advance the model by
    // the handshakes that happen at the coming rising edge. Called just after
    // a falling edge with inputs already driven.
    task automatic cycle(input string ph, input bit do_check, output bit acc);
        bit pa;
        bit pb;
        #1;
        if (do_check) check_outputs(ph);
        acc = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        pa  = a_ready && (qa.size() != 0);
        pb  = b_ready && (qb.size() != 0);
        if (b_valid && b_ready) rec_b.push_back(b_data);
        @(posedge clk);
        if (pa) begin last_a = qa.pop_front(); cnt_a++; end
        if (pb) begin last_b = qb.pop_front(); cnt_b++; end
        if (acc) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        bit hold;
        int i;
        int guard;

        in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
        @(negedge clk);
        apply_reset();

        // Reset state, in_ready for both selects
        in_sel = 1'b0; #1;
        check_outputs("rst_sel0");
        in_sel = 1'b1; #1;
        check_outputs("rst_sel1");
        @(negedge clk);

        // Basic routing with both consumers ready
        a_ready = 1; b_ready = 1;
        in_valid = 1; in_sel = 0; in_data = 32'h1111_1111;
        cycle("route0", 1, acc);
        in_sel = 1; in_data = 32'h2222_2222;
        cycle("route1", 1, acc);
        #1;
        chk("route.a_head", a_data, 32'h1111_1111);
        chk("route.b_head", b_data, 32'h2222_2222);
        in_valid = 0;
        cycle("route2", 1, acc);
        cycle("route3", 1, acc);

        // Backpressure: fill A, B still accepts
        a_ready = 0;
        in_valid = 1; in_sel = 0; in_data = 32'hA0; cycle("bp0", 1, acc);
        in_data = 32'hA1; cycle("bp1", 1, acc);
        in_data = 32'hA2; #1;
        chk("bp.full_sel0", 32'(in_ready), 32'd0);
        cycle("bp2", 1, acc);
        chk("bp.rejected", 32'(acc), 32'd0);
        in_sel = 1; in_data = 32'hB0; cycle("bp3", 1, acc);
        chk("bp.b_accept", 32'(acc), 32'd1);
        in_valid = 0; a_ready = 1;
        repeat (4) cycle("bp_drain", 1, acc);

        // Simultaneous push/pop on A with one entry
        a_ready = 0; in_valid = 1; in_sel = 0; in_data = 32'hC0;
        cycle("sim0", 1, acc);
        a_ready = 1; in_data = 32'hC1;
        cycle("sim1", 1, acc);
        in_valid = 0; a_ready = 0; #1;
        chk("sim.head", a_data, 32'hC1);
        chk("sim.in_ready", 32'(in_ready), 32'd1);
        cycle("sim2", 1, acc);
        a_ready = 1; cycle("sim3", 1, acc);

        // Wrap-around on B with toggling b_ready
        rec_b.delete();
        i = 1; guard = 0;
        b_ready = 0;
        while ((i <= 7 || qb.size() != 0) && guard < 100) begin
            in_valid = (i <= 7); in_sel = 1; in_data = 32'(i);
            b_ready = ~b_ready;
            cycle("wrap", 1, acc);
            if (acc) i++;
            guard++;
        end
        chk("wrap.timeout", 32'(guard < 100), 32'd1);
        chk("wrap.count", 32'(rec_b.size()), 32'd7);
        for (int k = 0; k < 7 && k < rec_b.size(); k++)
            chk("wrap.seq", rec_b[k], 32'(k + 1));
        in_valid = 0;

        // Randomized traffic; sel/data held while a word waits for acceptance
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) == 0);
            cycle("rand", 1, acc);
            hold = in_valid && !acc;
        end
        in_valid = 0; a_ready = 1; b_ready = 1;
        repeat (3) cycle("rand_drain", 1, acc);

        // Reset mid-operation with A full, asserted between edges
        a_ready = 0; in_valid = 1; in_sel = 0;
        in_data = 32'hD0; cycle("mid0", 1, acc);
        in_data = 32'hD1; cycle("mid1", 1, acc);
        in_valid = 0; #1;
        chk("mid.full", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("mid.a_valid", 32'(a_valid), 32'd0);
        chk("mid.a_data", a_data, 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1, acc);

`ifdef DEMUX_CNT_EN
        // Counter wrap on A: 0xFFFF pops from reset, then one more
        apply_reset();
        a_ready = 1; in_valid = 1; in_sel = 0;
        guard = 0;
        while (cnt_a != 16'hFFFF && guard < 70000) begin
            in_data = 32'(guard);
            cycle("cnt", 0, acc);
            guard++;
        end
        in_valid = 0;
        check_outputs("cnt_ffff");
        chk("cnt.at_ffff", 32'(a_count), 32'h0000_FFFF);
        cycle("cnt_wrap", 0, acc);
        #1;
        chk("cnt.wrapped", 32'(a_count), 32'd0);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 32-bit 1-to-2 demultiplexer with a valid/ready handshake; it is the steering counterpart of the 32-bit 2:1 select mux.
- Routes each input word to output A or output B according to a per-word select bit.
- Each output has its own small FIFO, so a stalled destination does not block words bound for the other destination unless the same select is presented.
- Sits between a producer (e.g. ALU/result stage) and two consumers (e.g. two register-write paths).

Parameters:
- WIDTH, 32, data width of input and outputs.
- DEPTH, 2, entries per output FIFO; power of two, min 2.
- CNT_W, 16, width of per-output transfer counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word accepted this cycle if in_valid=1.
- in_sel  input  1  destination: 0 = A, 1 = B; must be stable while in_valid=1.
- in_data  input  WIDTH  input word.
- a_valid  output  1  FIFO A non-empty.
- a_ready  input  1  consumer A takes head word.
- a_data  output  WIDTH  head of FIFO A.
- b_valid  output  1  FIFO B non-empty.
- b_ready  input  1  consumer B takes head word.
- b_data  output  WIDTH  head of FIFO B.
- a_count  output  CNT_W  words delivered on A (DEMUX_CNT_EN only).
- b_count  output  CNT_W  words delivered on B (DEMUX_CNT_EN only).

Behaviour:
- Reset (async, rst_n=0):
  - Both FIFOs empty; read/write pointers = 0.
  - a_valid = b_valid = 0; a_data = b_data = 0.
  - Counters = 0.
  - Leaving reset is synchronous to clk.
- in_ready = NOT full(FIFO[in_sel]). Combinational from in_sel and FIFO state only; no dependence on a_ready or b_ready.
- Push: in_valid & in_ready writes in_data into FIFO[in_sel] at its write pointer on the clock edge.
- Pop: x_valid & x_ready advances that FIFO's read pointer.
- x_data is the head entry while x_valid=1. When x_valid=0, x_data holds its last value (0 after reset).
- Latency: a word pushed at edge N is visible on x_valid/x_data after edge N (1 cycle). There is no same-cycle bypass from in_data to x_data.
- Per-FIFO occupancy states: EMPTY, PARTIAL, FULL. Pointers are log2(DEPTH)+1 bits. Empty when pointers are equal; full when indices are equal and the wrap bits differ.
- Transitions:
  - EMPTY: push → PARTIAL, or FULL if DEPTH=1 (not allowed).
  - PARTIAL: push only → occupancy +1 (FULL at DEPTH); pop only → occupancy −1 (EMPTY at 0); push and pop together → unchanged.
  - FULL: pop → PARTIAL. A push is impossible because in_ready=0.
- Simultaneous push and pop on the same FIFO in PARTIAL: both take effect; occupancy is unchanged.
- Push to A and pop from B in the same cycle: independent, no interaction.
- Pointer wrap: indices wrap modulo DEPTH; data ordering is preserved across the wrap (strict FIFO per output).
- A consumer asserting x_ready while x_valid=0 is ignored.
- in_valid=0 with in_sel toggling has no effect.
- Reset mid-operation: all stored words are discarded immediately; no output valid until a new push.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - a_count and b_count ports exist.
  - Each increments by 1 on every pop from its FIFO (x_valid & x_ready), not on push.
  - CNT_W bits, wraps from all-ones to 0; reset to 0.
- Undefined: both ports and their counter registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release → a_valid=b_valid=0, a_data=b_data=0, in_ready=1 for in_sel=0 and 1, counters=0.
- Basic routing, a_ready=b_ready=1: push 0x11111111 (sel 0), then 0x22222222 (sel 1) → a_data=0x11111111 one cycle after its push, b_data=0x22222222 one cycle after its push; each valid pulses exactly 1 cycle.
- Backpressure/full, DEPTH=2, a_ready=0: push 0xA0, 0xA1 to A → in_ready=0 with sel=0, in_ready=1 with sel=1. Push 0xB0 to B → accepted. Raise a_ready → pops 0xA0 then 0xA1, in order.
- Simultaneous push/pop on FIFO A holding 1 entry: push 0xC1 while popping 0xC0 → occupancy stays 1, next head 0xC1, in_ready remains 1.
- Wrap-around: 7 sequential words 0x1..0x7 to B, with b_ready toggling 1/0 every cycle → b_data sequence exactly 0x1..0x7, no loss or duplication.
- Reset mid-operation with FIFO A full: assert rst_n=0 asynchronously between edges → a_valid drops to 0 before the next edge. With DEMUX_CNT_EN, a_count returns to 0; after 0xFFFF pops on A from reset, one more pop shows a_count=0x0000.
